// File: rtl/gb_cpu_common_pkg.sv
// Shared types and helpers for the CPU front end: assembler states,
// the instruction record handed to the decoder, and the immediate-length table.
package gb_cpu_common_pkg;

  localparam logic [7:0] CB_PREFIX = 8'hCB;
  localparam int         GB_PC_W   = 16;

  typedef enum logic [2:0] {
    S_OPC,
    S_CB,
    S_LO,
    S_HI,
    S_OUT
  } fetchq_state_t;

  typedef struct packed {
    logic [7:0]         opcode;
    logic               cb;
    logic [15:0]        imm;
    logic [1:0]         len;
    logic [GB_PC_W-1:0] pc;
  } instr_rec_t;

  // Number of immediate bytes following an unprefixed LR35902 opcode.
  // CB-prefixed opcodes never carry immediates, so CB itself maps to 0.
  function automatic logic [1:0] gb_imm_bytes(logic [7:0] op);
    logic [1:0] n;
    n = 2'd0;
    case (op)
      // LD r,d8 / LD (HL),d8
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
      // STOP, JR r8, JR cc,r8
      8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
      // ALU A,d8
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      // LDH (a8),A / LDH A,(a8) / ADD SP,r8 / LD HL,SP+r8
      8'hE0, 8'hF0, 8'hE8, 8'hF8: n = 2'd1;
      // LD rr,d16 / LD (a16),SP
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
      // JP a16 / JP cc,a16
      8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
      // CALL a16 / CALL cc,a16
      8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC,
      // LD (a16),A / LD A,(a16)
      8'hEA, 8'hFA: n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/gb_cpu_byte_fifo.sv
// Byte FIFO for prefetched opcode bytes. Pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate counter.
module gb_cpu_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update; clear discards everything queued.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Byte storage write port.
  // NOTE: storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/gb_cpu_fetch_queue.sv
// Prefetch queue and instruction assembler: fetches sequential bytes into a
// small FIFO and builds {prefix, opcode, immediates} records for the decoder.
module gb_cpu_fetch_queue
  import gb_cpu_common_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic [ADDR_W-1:0]        flush_pc_i,
  output logic                     fetch_req_o,
  output logic [ADDR_W-1:0]        fetch_addr_o,
  input  logic                     fetch_ack_i,
  input  logic [7:0]               fetch_data_i,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic [7:0]               instr_opcode_o,
  output logic                     instr_cb_o,
  output logic [15:0]              instr_imm_o,
  output logic [1:0]               instr_len_o,
  output logic [ADDR_W-1:0]        instr_pc_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NW = CW + 1;

  logic [7:0]        head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              push;
  logic              pop;
  logic              req_d;
  logic [NW-1:0]     count_next;
  logic [1:0]        head_imm;

  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  fetchq_state_t     state;
  instr_rec_t        rec_q;
  logic              valid_q;
  logic [ADDR_W-1:0] pc_q;     // address of the byte currently at the FIFO head
  logic [1:0]        imm_n;    // immediate bytes of the instruction being assembled

  gb_cpu_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush_i),
    .push      (push),
    .push_data (fetch_data_i),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_imm = gb_imm_bytes(head);

  // Handshake decode and next request level from the post-edge occupancy.
  // NOTE: every signal gets a value on every path so no latch is inferred.
  always_comb begin
    push       = fetch_ack_i && req_q && !fifo_full && !flush_i;
    pop        = !fifo_empty && (state != S_OUT) && !flush_i;
    count_next = NW'(fifo_count) + NW'(push) - NW'(pop);
    req_d      = (count_next < NW'(DEPTH));
  end

  // Fetch control: one outstanding request, address advances on each ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= 1'b0;
      addr_q <= '0;
    end else if (flush_i) begin
      req_q  <= 1'b1;
      addr_q <= flush_pc_i;
    end else begin
      req_q <= req_d;
      if (push) addr_q <= addr_q + ADDR_W'(1);
    end
  end

  // Assembler FSM: consumes one head byte per cycle and builds the record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_OPC;
      rec_q   <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      imm_n   <= 2'd0;
    end else if (flush_i) begin
      state   <= S_OPC;
      valid_q <= 1'b0;
      pc_q    <= flush_pc_i;
    end else begin
      if (pop) pc_q <= pc_q + ADDR_W'(1);
      unique case (state)
        S_OPC: begin
          if (pop) begin
            rec_q.pc  <= GB_PC_W'(pc_q);
            rec_q.imm <= 16'h0000;
            if (head == CB_PREFIX) begin
              rec_q.cb  <= 1'b1;
              rec_q.len <= 2'd2;
              state     <= S_CB;
            end else begin
              rec_q.cb     <= 1'b0;
              rec_q.opcode <= head;
              rec_q.len    <= 2'd1 + head_imm;
              imm_n        <= head_imm;
              if (head_imm == 2'd0) begin
                state   <= S_OUT;
                valid_q <= 1'b1;
              end else begin
                state <= S_LO;
              end
            end
          end
        end
        S_CB: begin
          if (pop) begin
            rec_q.opcode <= head;
            state        <= S_OUT;
            valid_q      <= 1'b1;
          end
        end
        S_LO: begin
          if (pop) begin
            rec_q.imm[7:0] <= head;
            if (imm_n == 2'd1) begin
              state   <= S_OUT;
              valid_q <= 1'b1;
            end else begin
              state <= S_HI;
            end
          end
        end
        S_HI: begin
          if (pop) begin
            rec_q.imm[15:8] <= head;
            state           <= S_OUT;
            valid_q         <= 1'b1;
          end
        end
        S_OUT: begin
          if (instr_ready_i) begin
            valid_q <= 1'b0;
            state   <= S_OPC;
          end
        end
        default: state <= S_OPC;
      endcase
    end
  end

  assign fetch_req_o    = req_q;
  assign fetch_addr_o   = addr_q;
  assign instr_valid_o  = valid_q;
  assign instr_opcode_o = rec_q.opcode;
  assign instr_cb_o     = rec_q.cb;
  assign instr_imm_o    = rec_q.imm;
  assign instr_len_o    = rec_q.len;
  assign instr_pc_o     = ADDR_W'(rec_q.pc);
  assign fifo_count_o   = fifo_count;

endmodule

// File: tb/tb_gb_cpu_fetch_queue.sv
// Self-checking bench for gb_cpu_fetch_queue: a byte-addressed memory model
// answers fetches, and handshaken records are compared against constants and
// against a decoder model that walks memory instruction by instruction.
module tb_gb_cpu_fetch_queue;

  typedef struct packed {
    logic [7:0]  op;
    logic        cb;
    logic [15:0] imm;
    logic [1:0]  len;
    logic [15:0] pc;
  } tb_rec_t;

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [7:0]  op;
    logic        cb;
    logic [15:0] imm;
    logic [1:0]  len;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic [15:0] flush_pc_i;
  logic        fetch_req_o;
  logic [15:0] fetch_addr_o;
  logic        fetch_ack_i;
  logic [7:0]  fetch_data_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [7:0]  instr_opcode_o;
  logic        instr_cb_o;
  logic [15:0] instr_imm_o;
  logic [1:0]  instr_len_o;
  logic [15:0] instr_pc_o;
  logic [2:0]  fifo_count_o;

  logic [7:0]  mem [0:65535];
  tb_rec_t     got[$];
  tb_rec_t     exp_q[$];
  logic [15:0] ack_addrs[$];
  vec_t        vecs[14];
  int          checks   = 0;
  int          failures = 0;

  gb_cpu_fetch_queue #(.DEPTH(4), .ADDR_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .flush_pc_i     (flush_pc_i),
    .fetch_req_o    (fetch_req_o),
    .fetch_addr_o   (fetch_addr_o),
    .fetch_ack_i    (fetch_ack_i),
    .fetch_data_i   (fetch_data_i),
    .instr_valid_o  (instr_valid_o),
    .instr_ready_i  (instr_ready_i),
    .instr_opcode_o (instr_opcode_o),
    .instr_cb_o     (instr_cb_o),
    .instr_imm_o    (instr_imm_o),
    .instr_len_o    (instr_len_o),
    .instr_pc_o     (instr_pc_o),
    .fifo_count_o   (fifo_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic tb_rec_t mk(input logic [7:0] op, input logic cb, input logic [15:0] imm,
                                 input logic [1:0] len, input logic [15:0] pc);
    tb_rec_t r;
    r.op = op; r.cb = cb; r.imm = imm; r.len = len; r.pc = pc;
    return r;
  endfunction

  function automatic tb_rec_t dut_rec();
    return {instr_opcode_o, instr_cb_o, instr_imm_o, instr_len_o, instr_pc_o};
  endfunction

  // Immediate byte count of an unprefixed opcode, from the opcode map's columns.
  function automatic int ref_imm_len(input logic [7:0] op);
    if ((op[7:6] == 2'b00 || op[7:6] == 2'b11) && op[2:0] == 3'b110) return 1;
    if (op[7:6] == 2'b00 && op[2:0] == 3'b000 && op[5:4] != 2'b00)   return 1;
    if (op inside {8'hE0, 8'hF0, 8'hE8, 8'hF8})                       return 1;
    if (op == 8'h08)                                                  return 2;
    if (op[7:6] == 2'b00 && op[3:0] == 4'h1)                          return 2;
    if (op[7:5] == 3'b110 && (op[2:0] == 3'b010 || op[2:0] == 3'b100)) return 2;
    if (op inside {8'hC3, 8'hCD, 8'hEA, 8'hFA})                       return 2;
    return 0;
  endfunction

  // Walk memory from 'start' and list the next 'n' instructions.
  task automatic ref_decode(input logic [15:0] start, input int n);
    logic [15:0] at;
    tb_rec_t     r;
    int          k;
    at = start;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      r.pc = at;
      if (mem[at] == 8'hCB) begin
        r.cb = 1'b1; r.op = mem[16'(at + 1)]; r.imm = 16'h0000; r.len = 2'd2;
      end else begin
        k = ref_imm_len(mem[at]);
        r.cb  = 1'b0;
        r.op  = mem[at];
        r.imm = 16'h0000;
        if (k >= 1) r.imm[7:0]  = mem[16'(at + 1)];
        if (k == 2) r.imm[15:8] = mem[16'(at + 2)];
        r.len = 2'(k + 1);
      end
      exp_q.push_back(r);
      at = 16'(at + 16'(r.len));
    end
  endtask

  // One clock: drive inputs just after a falling edge, log a handshake if the
  // record will be accepted on the coming rising edge, then wait for the next falling edge.
  task automatic cycle(input bit ack_en, input bit rdy, input bit flush = 1'b0,
                       input logic [15:0] fpc = 16'h0000);
    fetch_ack_i   = ack_en && fetch_req_o;
    fetch_data_i  = mem[fetch_addr_o];
    instr_ready_i = rdy;
    flush_i       = flush;
    flush_pc_i    = fpc;
    if (fetch_ack_i) ack_addrs.push_back(fetch_addr_o);
    if (instr_valid_o && rdy && rst_n) got.push_back(dut_rec());
    @(negedge clk);
  endtask

  task automatic restart(input logic [15:0] pc, input bit rdy);
    cycle(1'b1, rdy, 1'b1, pc);
    got.delete();
    ack_addrs.delete();
  endtask

  task automatic run_until(input int n, input int max_cycles);
    for (int k = 0; k < max_cycles && got.size() < n; k++) cycle(1'b1, 1'b1);
  endtask

  task automatic check_got(input string name, input int idx, input tb_rec_t exp);
    if (got.size() > idx) check(name, got[idx], exp);
    else                  check({name, "_count"}, got.size(), idx + 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, instr_valid_o, 0);
    check({tag, "_req"},   fetch_req_o,   0);
    check({tag, "_addr"},  fetch_addr_o,  0);
    check({tag, "_count"}, fifo_count_o,  0);
    check({tag, "_rec"},   dut_rec(),     0);
  endtask

  initial begin
    int          first_ack;
    int          first_valid;
    int          unstable;
    int          gaps;
    bit          seen;
    tb_rec_t     snap;
    logic [15:0] base;

    vecs[0]  = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0000, 2'd1};
    vecs[1]  = '{8'h06, 8'h11, 8'h00, 8'h06, 1'b0, 16'h0011, 2'd2};
    vecs[2]  = '{8'h01, 8'hCD, 8'hAB, 8'h01, 1'b0, 16'hABCD, 2'd3};
    vecs[3]  = '{8'h18, 8'hFE, 8'h00, 8'h18, 1'b0, 16'h00FE, 2'd2};
    vecs[4]  = '{8'hCB, 8'h7C, 8'h00, 8'h7C, 1'b1, 16'h0000, 2'd2};
    vecs[5]  = '{8'hCD, 8'h00, 8'h40, 8'hCD, 1'b0, 16'h4000, 2'd3};
    vecs[6]  = '{8'hE0, 8'h44, 8'h00, 8'hE0, 1'b0, 16'h0044, 2'd2};
    vecs[7]  = '{8'hEA, 8'h10, 8'hC0, 8'hEA, 1'b0, 16'hC010, 2'd3};
    vecs[8]  = '{8'hF8, 8'h02, 8'h00, 8'hF8, 1'b0, 16'h0002, 2'd2};
    vecs[9]  = '{8'h76, 8'h00, 8'h00, 8'h76, 1'b0, 16'h0000, 2'd1};
    vecs[10] = '{8'h10, 8'h00, 8'h00, 8'h10, 1'b0, 16'h0000, 2'd2};
    vecs[11] = '{8'hFE, 8'h3F, 8'h00, 8'hFE, 1'b0, 16'h003F, 2'd2};
    vecs[12] = '{8'hD3, 8'h00, 8'h00, 8'hD3, 1'b0, 16'h0000, 2'd1};
    vecs[13] = '{8'hCB, 8'hCB, 8'h00, 8'hCB, 1'b1, 16'h0000, 2'd2};

    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    rst_n = 1'b0; flush_i = 1'b0; flush_pc_i = 16'h0000;
    fetch_ack_i = 1'b0; fetch_data_i = 8'h00; instr_ready_i = 1'b0;
    @(negedge clk); @(negedge clk);

    // Reset state and a stream of 1-byte opcodes.
    check_reset_outputs("reset");
    mem[0] = 8'h00; mem[1] = 8'h3C;
    rst_n = 1'b1;
    cycle(1'b1, 1'b1);
    check("req_after_reset", fetch_req_o, 1);
    check("addr_after_reset", fetch_addr_o, 16'h0000);
    first_ack = -1; first_valid = -1;
    for (int k = 0; k < 20; k++) begin
      if (first_valid < 0 && instr_valid_o) first_valid = k;
      if (first_ack < 0 && fetch_req_o) first_ack = k;
      cycle(1'b1, 1'b1);
    end
    check("first_valid_latency", first_valid - first_ack, 2);
    check_got("nop_rec", 0, mk(8'h00, 1'b0, 16'h0000, 2'd1, 16'h0000));
    check_got("inc_rec", 1, mk(8'h3C, 1'b0, 16'h0000, 2'd1, 16'h0001));

    // Immediates: LD A,n then JP nn.
    mem[0] = 8'h3E; mem[1] = 8'h42; mem[2] = 8'hC3; mem[3] = 8'h34; mem[4] = 8'h12;
    restart(16'h0000, 1'b1);
    run_until(2, 30);
    check_got("ld_a_n", 0, mk(8'h3E, 1'b0, 16'h0042, 2'd2, 16'h0000));
    check_got("jp_nn",  1, mk(8'hC3, 1'b0, 16'h1234, 2'd3, 16'h0002));

    // CB prefix followed by an unprefixed opcode.
    mem[16'h0100] = 8'hCB; mem[16'h0101] = 8'h37; mem[16'h0102] = 8'hAF;
    restart(16'h0100, 1'b1);
    run_until(2, 30);
    check_got("cb_swap", 0, mk(8'h37, 1'b1, 16'h0000, 2'd2, 16'h0100));
    check_got("xor_a",   1, mk(8'hAF, 1'b0, 16'h0000, 2'd1, 16'h0102));

    // Backpressure: hold ready low, FIFO fills, record stays put.
    mem[16'h0200] = 8'h3C; mem[16'h0201] = 8'h04; mem[16'h0202] = 8'h0C;
    mem[16'h0203] = 8'h14; mem[16'h0204] = 8'h1C; mem[16'h0205] = 8'h24;
    mem[16'h0206] = 8'h2C; mem[16'h0207] = 8'h3E; mem[16'h0208] = 8'h55;
    ref_decode(16'h0200, 8);
    restart(16'h0200, 1'b0);
    seen = 1'b0; unstable = 0; snap = '0;
    for (int k = 0; k < 20; k++) begin
      if (seen) begin
        if (!instr_valid_o || dut_rec() != snap) unstable++;
      end else if (instr_valid_o) begin
        seen = 1'b1;
        snap = dut_rec();
      end
      cycle(1'b1, 1'b0);
    end
    check("bp_seen_valid", seen, 1);
    check("bp_first_rec", snap, mk(8'h3C, 1'b0, 16'h0000, 2'd1, 16'h0200));
    check("bp_unstable_cycles", unstable, 0);
    check("bp_count_full", fifo_count_o, 4);
    check("bp_req_low", fetch_req_o, 0);
    run_until(8, 40);
    for (int i = 0; i < 8; i++) check_got($sformatf("bp_order_%0d", i), i, exp_q[i]);

    // Flush while JP nn is waiting for its low immediate, with an ack in the flush cycle.
    mem[16'h0300] = 8'hC3; mem[16'h0301] = 8'hAA; mem[16'h0302] = 8'hBB;
    restart(16'h0300, 1'b1);
    cycle(1'b1, 1'b1);                       // C3 arrives in the FIFO
    cycle(1'b1, 1'b1);                       // C3 consumed, low byte arriving
    cycle(1'b1, 1'b1, 1'b1, 16'h0150);       // assembler waits on imm lo
    check("flush_valid", instr_valid_o, 0);
    check("flush_count", fifo_count_o, 0);
    check("flush_addr", fetch_addr_o, 16'h0150);
    check("flush_req_resumes", fetch_req_o, 1);
    got.delete();
    run_until(1, 20);
    check_got("flush_next_rec", 0, mk(8'h00, 1'b0, 16'h0000, 2'd1, 16'h0150));

    // Single-instruction vectors across the immediate-length table.
    for (int i = 0; i < 14; i++) begin
      base = 16'h0400 + 16'(i * 4);
      mem[base] = vecs[i].b0; mem[16'(base + 1)] = vecs[i].b1;
      mem[16'(base + 2)] = vecs[i].b2; mem[16'(base + 3)] = 8'h00;
      restart(base, 1'b1);
      run_until(1, 20);
      check_got($sformatf("vec_%0d_op%0h", i, vecs[i].b0), 0,
                mk(vecs[i].op, vecs[i].cb, vecs[i].imm, vecs[i].len, base));
    end

    // Random bytes with random bus stalls and consumer backpressure.
    for (int a = 16'h1000; a < 16'h2000; a++) mem[a] = 8'($urandom_range(0, 255));
    ref_decode(16'h1000, 800);
    restart(16'h1000, 1'b1);
    for (int k = 0; k < 1500; k++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    check("rand_progress", got.size() >= 100, 1);
    gaps = 0;
    for (int i = 1; i < ack_addrs.size(); i++)
      if (ack_addrs[i] != 16'(ack_addrs[i-1] + 1)) gaps++;
    check("rand_fetch_sequential", gaps, 0);
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("rand_%0d", i), got[i], exp_q[i]);

    // Address wrap from FFFF to 0000.
    mem[16'hFFFF] = 8'h3E; mem[16'h0000] = 8'h99; mem[16'h0001] = 8'h3C;
    restart(16'hFFFF, 1'b1);
    run_until(1, 20);
    check_got("wrap_rec", 0, mk(8'h3E, 1'b0, 16'h0099, 2'd2, 16'hFFFF));
    if (ack_addrs.size() > 1) check("wrap_second_addr", ack_addrs[1], 16'h0000);
    else                      check("wrap_ack_count", ack_addrs.size(), 2);

    // Asynchronous reset while a record is presented.
    for (int k = 0; k < 20 && !instr_valid_o; k++) cycle(1'b1, 1'b0);
    check("pre_reset_valid", instr_valid_o, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    ack_addrs.delete();
    cycle(1'b1, 1'b1);
    check("restart_req", fetch_req_o, 1);
    check("restart_addr", fetch_addr_o, 16'h0000);
    cycle(1'b1, 1'b1);
    if (ack_addrs.size() > 0) check("restart_first_ack_addr", ack_addrs[0], 16'h0000);
    else                      check("restart_ack_count", ack_addrs.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
